// File: rtl/l2_bank_arbiter_if.sv
// Requester-side and bank-side signal bundle of the L2 bank arbiter.
// The slave modport is the arbiter; the master side drives requests and returns bank read data.
interface l2_bank_arbiter_if #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned NB_BANKS       = 4,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 18,
    parameter int unsigned MEM_ADDR_WIDTH = 13
);
    logic [N_REQ-1:0]                    req_i;
    logic [N_REQ*ADDR_WIDTH-1:0]         add_i;
    logic [N_REQ-1:0]                    wen_i;
    logic [N_REQ*DATA_WIDTH-1:0]         wdata_i;
    logic [N_REQ*DATA_WIDTH/8-1:0]       be_i;
    logic [N_REQ-1:0]                    gnt_o;
    logic [N_REQ-1:0]                    r_valid_o;
    logic [N_REQ*DATA_WIDTH-1:0]         r_rdata_o;
    logic [NB_BANKS-1:0]                 CEN_o;
    logic [NB_BANKS-1:0]                 WEN_o;
    logic [NB_BANKS*MEM_ADDR_WIDTH-1:0]  A_o;
    logic [NB_BANKS*DATA_WIDTH-1:0]      D_o;
    logic [NB_BANKS*DATA_WIDTH/8-1:0]    BE_o;
    logic [NB_BANKS*DATA_WIDTH-1:0]      Q_i;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i, Q_i,
        output gnt_o, r_valid_o, r_rdata_o, CEN_o, WEN_o, A_o, D_o, BE_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i, Q_i,
        input  gnt_o, r_valid_o, r_rdata_o, CEN_o, WEN_o, A_o, D_o, BE_o
    );
endinterface

// File: rtl/l2_bank_arbiter.sv
// Per-bank scheduler between word requesters and single-port L2 banks: bounded HP priority,
// round-robin among LP requesters, responses routed back to the granted requester one cycle later.
module l2_bank_arbiter #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned HP_ID          = 2,
    parameter int unsigned NB_BANKS       = 4,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 18,
    parameter int unsigned MEM_ADDR_WIDTH = 13,
    parameter int unsigned STARVE_MAX     = 8
) (
    input logic              ACLK,
    input logic              ARESET,
    l2_bank_arbiter_if.slave bus
);
    localparam int unsigned BE_W     = DATA_WIDTH / 8;
    localparam int unsigned OFFSET   = $clog2(BE_W);
    localparam int unsigned BANK_W   = $clog2(NB_BANKS);
    localparam int unsigned IDX_W    = $clog2(N_REQ);
    localparam int unsigned LP_FIRST = (HP_ID == 0) ? 1 : 0;
    localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [N_REQ-1:0] HP_MASK = N_REQ'(1) << HP_ID;

    typedef logic [IDX_W-1:0] idx_t;

    // Next LP index after cur in circular order, never landing on the HP requester.
    function automatic idx_t next_lp(input idx_t cur);
        int unsigned n;
        n = (32'(cur) + 32'd1) % N_REQ;
        if (n == HP_ID) n = (n + 32'd1) % N_REQ;
        return idx_t'(n);
    endfunction

    logic [BANK_W-1:0]         req_bank  [N_REQ];
    logic [MEM_ADDR_WIDTH-1:0] req_row   [N_REQ];
    logic [DATA_WIDTH-1:0]     req_wdata [N_REQ];
    logic [BE_W-1:0]           req_be    [N_REQ];

    logic [N_REQ-1:0]    bank_req [NB_BANKS];
    logic [NB_BANKS-1:0] lp_pend;
    logic [NB_BANKS-1:0] win_hp;
    logic [NB_BANKS-1:0] win_vld;
    idx_t                win_idx  [NB_BANKS];

    idx_t                rr_ptr_q    [NB_BANKS];
    idx_t                rr_ptr_d    [NB_BANKS];
    logic [7:0]          starve_q    [NB_BANKS];
    logic [7:0]          starve_d    [NB_BANKS];
    idx_t                owner_q     [NB_BANKS];
    logic [NB_BANKS-1:0] owner_vld_q;

    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            req_bank[r]  = bus.add_i[r*ADDR_WIDTH+OFFSET +: BANK_W];
            req_row[r]   = bus.add_i[r*ADDR_WIDTH+OFFSET+BANK_W +: MEM_ADDR_WIDTH];
            req_wdata[r] = bus.wdata_i[r*DATA_WIDTH +: DATA_WIDTH];
            req_be[r]    = bus.be_i[r*BE_W +: BE_W];
        end
    end

    always_comb begin
        logic        lp_found;
        idx_t        lp_idx;
        int unsigned cand;
        lp_found = 1'b0;
        lp_idx   = '0;
        cand     = 0;
        for (int b = 0; b < NB_BANKS; b++) begin
            bank_req[b] = '0;
            for (int r = 0; r < N_REQ; r++) begin
                bank_req[b][r] = bus.req_i[r] && (req_bank[r] == BANK_W'(b));
            end
            lp_pend[b] = |(bank_req[b] & ~HP_MASK);
            lp_found   = 1'b0;
            lp_idx     = rr_ptr_q[b];
            // Circular search starting at rr_ptr; the HP slot is skipped.
            for (int k = 0; k < N_REQ; k++) begin
                cand = (32'(rr_ptr_q[b]) + 32'(k)) % N_REQ;
                if (!lp_found && cand != HP_ID && bank_req[b][idx_t'(cand)]) begin
                    lp_found = 1'b1;
                    lp_idx   = idx_t'(cand);
                end
            end
            win_hp[b]  = bank_req[b][HP_ID] && (!lp_pend[b] || starve_q[b] < STARVE_LIM);
            win_vld[b] = win_hp[b] || lp_found;
            win_idx[b] = win_hp[b] ? idx_t'(HP_ID) : lp_idx;
        end
    end

    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            rr_ptr_d[b] = rr_ptr_q[b];
            starve_d[b] = starve_q[b];
            if (win_vld[b] && !win_hp[b]) begin
                rr_ptr_d[b] = next_lp(win_idx[b]);
                starve_d[b] = '0;
            end else if (!lp_pend[b]) begin
                starve_d[b] = '0;
            end else if (win_hp[b] && starve_q[b] != 8'hFF) begin
                starve_d[b] = starve_q[b] + 8'd1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int b = 0; b < NB_BANKS; b++) begin
                rr_ptr_q[b] <= idx_t'(LP_FIRST);
                starve_q[b] <= '0;
                owner_q[b]  <= '0;
            end
            owner_vld_q <= '0;
        end else begin
            for (int b = 0; b < NB_BANKS; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
                starve_q[b] <= starve_d[b];
                owner_q[b]  <= win_idx[b];
            end
            owner_vld_q <= win_vld;
        end
    end

    // Grants and bank drives are masked during reset so the outputs idle asynchronously.
    always_comb begin
        bus.gnt_o = '0;
        bus.CEN_o = '1;
        bus.WEN_o = '1;
        bus.A_o   = '0;
        bus.D_o   = '0;
        bus.BE_o  = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            if (win_vld[b] && !ARESET) begin
                bus.gnt_o[win_idx[b]] = 1'b1;
                bus.CEN_o[b]          = 1'b0;
                bus.WEN_o[b]          = bus.wen_i[win_idx[b]];
                bus.A_o[b*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = req_row[win_idx[b]];
                bus.D_o[b*DATA_WIDTH +: DATA_WIDTH]         = req_wdata[win_idx[b]];
                bus.BE_o[b*BE_W +: BE_W]                    = req_be[win_idx[b]];
            end
        end
    end

    always_comb begin
        bus.r_valid_o = '0;
        bus.r_rdata_o = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            if (owner_vld_q[b]) begin
                bus.r_valid_o[owner_q[b]] = 1'b1;
                bus.r_rdata_o[32'(owner_q[b])*DATA_WIDTH +: DATA_WIDTH] =
                    bus.Q_i[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Self-checking bench for l2_bank_arbiter: vector table plus starvation and reset sequences,
// with a simple SRAM bank model and a response scoreboard.
module tb_l2_bank_arbiter;
    localparam int NR  = 3;
    localparam int NB  = 4;
    localparam int DW  = 64;
    localparam int AW  = 18;
    localparam int MAW = 13;

    typedef struct {
        logic [2:0]   req;
        logic [5:0]   bank;
        logic [38:0]  row;
        logic [2:0]   wen;
        logic [191:0] wdata;
        logic [23:0]  be;
        logic [2:0]   gnt;
        logic [3:0]   cen;
    } vec_t;

    typedef struct {
        logic [2:0]   vld;
        logic [2:0]   rmask;
        logic [191:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    resp_t         resp_q [$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] sram [NB][1<<MAW];
    logic [DW-1:0] q [NB];
    vec_t          tbl [17];

    always #5 clk = ~clk;

    l2_bank_arbiter_if #(
        .N_REQ(NR), .NB_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)
    ) bus ();

    l2_bank_arbiter #(
        .N_REQ(NR), .HP_ID(2), .NB_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MEM_ADDR_WIDTH(MAW), .STARVE_MAX(8)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    // Single-port SRAM banks: read data appears the cycle after CEN low.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!bus.CEN_o[b]) begin
                if (bus.WEN_o[b]) begin
                    q[b] <= sram[b][bus.A_o[b*MAW +: MAW]];
                end else begin
                    for (int k = 0; k < 8; k++) begin
                        if (bus.BE_o[b*8+k])
                            sram[b][bus.A_o[b*MAW +: MAW]][k*8 +: 8] <= bus.D_o[b*DW+k*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) bus.Q_i[b*DW +: DW] = q[b];
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] wd(input int r, input int b, input int row);
        return {16'hDA7A, 14'h0, 2'(b), 16'(row), 16'hC0DE ^ 16'(r)};
    endfunction

    function automatic vec_t mk(input logic [2:0] req, input int b0, input int r0,
                                input int b1, input int r1, input int b2, input int r2,
                                input logic [2:0] wen, input logic [2:0] gnt,
                                input logic [3:0] cen);
        vec_t v;
        v.req   = req;
        v.wen   = wen;
        v.gnt   = gnt;
        v.cen   = cen;
        v.be    = '1;
        v.bank  = {2'(b2), 2'(b1), 2'(b0)};
        v.row   = {13'(r2), 13'(r1), 13'(r0)};
        v.wdata = {wd(2, b2, r2), wd(1, b1, r1), wd(0, b0, r0)};
        return v;
    endfunction

    task automatic check_resp(input string tag);
        resp_t e;
        if (resp_q.size() > 0) begin
            e = resp_q.pop_front();
        end else begin
            e.vld   = '0;
            e.rmask = '0;
            e.data  = '0;
        end
        chk({tag, " r_valid"}, 192'(bus.r_valid_o), 192'(e.vld));
        for (int r = 0; r < NR; r++) begin
            if (e.rmask[r])
                chk({tag, " r_rdata"}, 192'(bus.r_rdata_o[r*DW +: DW]), 192'(e.data[r*DW +: DW]));
        end
    endtask

    // One cycle: drive after the edge, check outputs late in the cycle, queue the response.
    task automatic step(input vec_t v, input string tag);
        resp_t         e;
        int            b;
        int            key;
        logic [DW-1:0] word;
        @(posedge clk);
        #1;
        bus.req_i   = v.req;
        bus.wen_i   = v.wen;
        bus.wdata_i = v.wdata;
        bus.be_i    = v.be;
        for (int r = 0; r < NR; r++)
            bus.add_i[r*AW +: AW] = {v.row[r*13 +: 13], v.bank[r*2 +: 2], 3'b000};
        #3;
        check_resp(tag);
        chk({tag, " gnt"}, 192'(bus.gnt_o), 192'(v.gnt));
        chk({tag, " CEN"}, 192'(bus.CEN_o), 192'(v.cen));
        e.vld   = v.gnt;
        e.rmask = '0;
        e.data  = '0;
        for (int r = 0; r < NR; r++) begin
            if (v.gnt[r]) begin
                b   = int'(v.bank[r*2 +: 2]);
                key = b * 8192 + int'(v.row[r*13 +: 13]);
                chk({tag, " A"}, 192'(bus.A_o[b*MAW +: MAW]), 192'(v.row[r*13 +: 13]));
                chk({tag, " WEN"}, 192'(bus.WEN_o[b]), 192'(v.wen[r]));
                if (v.wen[r]) begin
                    if (ref_mem.exists(key)) begin
                        e.rmask[r]         = 1'b1;
                        e.data[r*DW +: DW] = ref_mem[key];
                    end
                end else begin
                    word = ref_mem.exists(key) ? ref_mem[key] : '0;
                    for (int k = 0; k < 8; k++)
                        if (v.be[r*8+k]) word[k*8 +: 8] = v.wdata[r*DW+k*8 +: 8];
                    ref_mem[key] = word;
                end
            end
        end
        resp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bus.req_i   = '0;
        bus.add_i   = '0;
        bus.wen_i   = '1;
        bus.wdata_i = '0;
        bus.be_i    = '1;

        // Reset holds every output idle even with a live request.
        #1;
        bus.req_i = 3'b001;
        #1;
        chk("reset gnt", 192'(bus.gnt_o), 192'(3'b000));
        chk("reset CEN", 192'(bus.CEN_o), 192'(4'hF));
        chk("reset WEN", 192'(bus.WEN_o), 192'(4'hF));
        chk("reset A", 192'(bus.A_o), 192'(0));
        chk("reset r_valid", 192'(bus.r_valid_o), 192'(3'b000));
        chk("reset r_rdata", bus.r_rdata_o, 192'(0));
        #6;
        bus.req_i = '0;
        rst       = 1'b0;

        tbl[0]  = mk(3'b001, 3, 0, 0, 0, 0, 0, 3'b110, 3'b001, 4'b0111);
        tbl[0].wdata[63:0] = 64'hA5A5_A5A5_A5A5_A5A5;
        tbl[1]  = mk(3'b010, 0, 0, 3, 0, 0, 0, 3'b111, 3'b010, 4'b0111);
        tbl[2]  = mk(3'b111, 0, 1, 1, 5, 2, 3, 3'b000, 3'b111, 4'b1000);
        tbl[3]  = mk(3'b001, 0, 2, 0, 0, 0, 0, 3'b110, 3'b001, 4'b1110);
        tbl[4]  = mk(3'b110, 0, 0, 2, 9, 1, 7, 3'b001, 3'b110, 4'b1001);
        tbl[5]  = mk(3'b001, 1, 8, 0, 0, 0, 0, 3'b110, 3'b001, 4'b1101);
        tbl[6]  = mk(3'b011, 0, 1, 0, 2, 0, 0, 3'b111, 3'b010, 4'b1110);
        tbl[7]  = mk(3'b011, 0, 1, 0, 2, 0, 0, 3'b111, 3'b001, 4'b1110);
        tbl[8]  = mk(3'b011, 0, 1, 0, 2, 0, 0, 3'b111, 3'b010, 4'b1110);
        tbl[9]  = mk(3'b011, 0, 1, 0, 2, 0, 0, 3'b111, 3'b001, 4'b1110);
        tbl[10] = mk(3'b111, 0, 1, 1, 5, 2, 3, 3'b111, 3'b111, 4'b1000);
        tbl[11] = mk(3'b010, 0, 0, 1, 5, 0, 0, 3'b101, 3'b010, 4'b1101);
        tbl[11].wdata[127:64] = '1;
        tbl[11].be[15:8]      = 8'h0F;
        tbl[12] = mk(3'b010, 0, 0, 1, 5, 0, 0, 3'b111, 3'b010, 4'b1101);
        tbl[13] = mk(3'b111, 1, 8, 1, 5, 0, 1, 3'b111, 3'b101, 4'b1100);
        tbl[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000, 4'b1111);
        tbl[15] = mk(3'b101, 3, 0, 0, 0, 3, 0, 3'b111, 3'b100, 4'b0111);
        tbl[16] = mk(3'b001, 3, 0, 0, 0, 0, 0, 3'b111, 3'b001, 4'b0111);

        for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("tbl[%0d]", i));

        // HP and req0 contend for bank 1: eight HP wins, then req0 is forced through.
        for (int i = 0; i < 18; i++) begin
            v = mk(3'b101, 1, 8, 0, 0, 1, 7, 3'b111, (i % 9 == 8) ? 3'b001 : 3'b100, 4'b1101);
            step(v, $sformatf("starve[%0d]", i));
        end

        // Withdrawing the LP request clears the count; the next LP waits a full eight cycles.
        for (int i = 0; i < 15; i++) begin
            v = mk((i == 5) ? 3'b100 : 3'b101, 1, 8, 0, 0, 1, 7, 3'b111,
                   (i == 14) ? 3'b001 : 3'b100, 4'b1101);
            step(v, $sformatf("clear[%0d]", i));
        end

        // Asynchronous reset while a response is on the bus.
        step(mk(3'b010, 0, 0, 2, 9, 0, 0, 3'b111, 3'b010, 4'b1011), "pre_rst");
        @(posedge clk);
        #2;
        check_resp("pre_rst resp");
        #1;
        rst = 1'b1;
        #1;
        chk("async rst gnt", 192'(bus.gnt_o), 192'(3'b000));
        chk("async rst CEN", 192'(bus.CEN_o), 192'(4'hF));
        chk("async rst r_valid", 192'(bus.r_valid_o), 192'(3'b000));
        resp_q.delete();
        @(posedge clk);
        #3;
        bus.req_i = '0;
        rst       = 1'b0;
        #1;
        chk("post rst r_valid", 192'(bus.r_valid_o), 192'(3'b000));

        // Round-robin pointer restarts at requester 0.
        step(mk(3'b011, 1, 8, 1, 5, 0, 0, 3'b111, 3'b001, 4'b1101), "post_rst rr0");
        step(mk(3'b010, 1, 8, 1, 5, 0, 0, 3'b111, 3'b010, 4'b1101), "post_rst rr1");
        step(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000, 4'b1111), "drain0");
        step(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000, 4'b1111), "drain1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_bank_arbiter.md
# l2_bank_arbiter

Per-bank request scheduler for the multi-bank L2. It sits between N_REQ word-level requesters (LP AXI write controller, LP AXI read controller, HP direct port) and NB_BANKS single-port SRAM banks. Each cycle it decodes every request's bank from the interleaved address and grants at most one requester per bank. The HP requester has priority, bounded by an anti-starvation counter; the LP requesters share round-robin. Read data and response valids return to the granted requester one cycle later.

## Interface
- N_REQ, 3, number of requesters (≥2)
- HP_ID, 2, index of the high-priority requester
- NB_BANKS, 4, number of banks (power of two)
- DATA_WIDTH, 64, word width in bits
- ADDR_WIDTH, 18, byte-address width per requester
- MEM_ADDR_WIDTH, 13, bank row address width
- STARVE_MAX, 8, consecutive HP-won cycles before a waiting LP request is forced through (1..255)

Ports:
- ACLK  in  1  clock, all state on rising edge
- ARESET  in  1  reset, asynchronous and active-high
- req_i  in  N_REQ  request per requester
- add_i  in  N_REQ*ADDR_WIDTH  byte address per requester
- wen_i  in  N_REQ  1 = read, 0 = write
- wdata_i  in  N_REQ*DATA_WIDTH  write data
- be_i  in  N_REQ*DATA_WIDTH/8  byte enables
- gnt_o  out  N_REQ  grant, same cycle as req
- r_valid_o  out  N_REQ  response valid, one cycle after grant
- r_rdata_o  out  N_REQ*DATA_WIDTH  read data, qualified by r_valid_o
- CEN_o  out  NB_BANKS  bank enable, active-low
- WEN_o  out  NB_BANKS  1 = read
- A_o  out  NB_BANKS*MEM_ADDR_WIDTH  row address
- D_o  out  NB_BANKS*DATA_WIDTH  write data
- BE_o  out  NB_BANKS*DATA_WIDTH/8  byte enables
- Q_i  in  NB_BANKS*DATA_WIDTH  bank read data, valid the cycle after CEN low

## Operation
- OFFSET = log2(DATA_WIDTH/8). The bank is add[OFFSET +: log2 NB_BANKS]. The row is add[OFFSET+log2 NB_BANKS +: MEM_ADDR_WIDTH]. Higher address bits are ignored.
- Protocol: a requester holds req and its payload stable until gnt. A requester targets one bank per cycle.
- Per-bank state:
  - rr_ptr: the next LP index to consider first. It never equals HP_ID.
  - starve_cnt: 8 bits.
  - owner_q: the requester index granted last cycle.
  - owner_vld_q.
- Per-bank arbitration is combinational:
  - LP winner: the first requesting LP index at or after rr_ptr, wrapping modulo N_REQ and skipping HP_ID.
  - If HP requests the bank and (no LP requests it, or starve_cnt < STARVE_MAX), HP wins.
  - Otherwise the LP winner wins.
- rr_ptr update: only on an LP grant, to the next LP index after the winner (wrapping, skipping HP_ID).
- starve_cnt update:
  - Increments (saturating at 255) when HP wins while an LP request to that bank is pending.
  - Clears when an LP is granted, or when no LP request targets the bank.
- Granted payload drives the bank port: CEN_o=0, with WEN/A/D/BE taken from the winner. Idle banks have CEN_o=1, and WEN/A/D/BE are held at 0/1-don't-care.
- owner_q and owner_vld_q register the winner index and a grant flag.
- Next cycle: r_valid_o[owner_q]=1 for both reads and writes. r_rdata_o[owner_q] = that bank's Q_i.
- Since each requester has at most one grant per cycle, r_valid is one-hot per requester.

## Timing
- Grant latency: 0 cycles (combinational from req/add).
- Response latency: exactly 1 cycle after the gnt cycle.
- Back-to-back grants to the same requester are allowed every cycle (full throughput per bank).
- Reset (ARESET high, asynchronous), outputs:
  - gnt_o=0, CEN_o all 1, r_valid_o=0, r_rdata_o=0.
  - Other bank outputs are 0, except WEN_o=1.
- Reset, state: rr_ptr = lowest LP index, starve_cnt=0, owner_vld_q=0.
- Reset mid-transaction: the pending response is dropped (no r_valid after release). The first cycle after deassert arbitrates normally.
- Simultaneous events:
  - When HP and one LP target different banks, both are granted in the same cycle.
  - When the forcing threshold coincides with a new HP request, the LP wins and starve_cnt returns to 0.
- rr_ptr wrap: with N_REQ=3 and HP_ID=2, the LP order is 0,1,0,1,…

## Test plan
- Reset then idle: ARESET pulsed mid-cycle → CEN_o=4'hF, gnt_o=0, r_valid_o=0 asynchronously. No response appears for a read granted in the reset cycle.
- Bank decode and read:
  - Stimulus: req0 write 0xA5A5… to add 0x0018 (bank 3, row 0); one cycle later, req1 reads 0x0018.
  - Required: gnt same cycle each time; CEN_o=4'b0111, A_o bank3 row=0; r_valid_o[1] one cycle after its grant with r_rdata=0xA5A5…
- LP round-robin: req0 and req1 both read bank 0 every cycle for 4 cycles → grants 0,1,0,1. Each r_valid follows its grant by 1 cycle.
- HP priority with starvation cap (STARVE_MAX=8): HP and req0 continuously target bank 1 → HP granted 8 cycles, req0 granted on the 9th, HP again on the 10th. starve_cnt is observed 0 after the LP grant.
- Parallel banks: HP → bank 2, req0 → bank 0, req1 → bank 1 in the same cycle → gnt_o=3'b111, CEN_o=4'b1000. Next cycle r_valid_o=3'b111 with data from the matching banks.
- Starve clear: LP request withdrawn after 5 HP-won cycles → starve_cnt=0. A new LP request then waits a full 8 cycles before being forced.
